// File: rtl/sub_seq_pkg.sv
// rtl/sub_seq_pkg.sv - shared types and constants for the serial subtractor sequencer
package sub_seq_pkg;

  // Sequencer states; encoding 3 is unreachable
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;
  localparam int OP_COUNT_W    = 8;

endpackage

// File: rtl/sub_sequencer_if.sv
// rtl/sub_sequencer_if.sv - request/result bundle between a requester and the subtractor sequencer
interface sub_sequencer_if
  import sub_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic                  start;
  logic [WIDTH-1:0]      x;
  logic [WIDTH-1:0]      y;
  logic                  busy;
  logic                  done;
  logic [WIDTH-1:0]      diff;
  logic                  borrow;
  logic [OP_COUNT_W-1:0] op_count;

  // Requester side: issues operands and start, observes results
  modport master (
    output start, x, y,
    input  busy, done, diff, borrow, op_count
  );

  // Sequencer side: consumes operands, produces results
  modport slave (
    input  start, x, y,
    output busy, done, diff, borrow, op_count
  );

endinterface

// File: rtl/sub_cell.sv
// rtl/sub_cell.sv - one-bit full subtractor cell
module sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/sub_sequencer.sv
// rtl/sub_sequencer.sv - bit-serial unsigned subtractor, LSB first, one cell reused per bit
module sub_sequencer
  import sub_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic          CLOCK_50,
  input  logic          RESET_N,
  sub_sequencer_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  typedef logic [CW-1:0]         cnt_t;
  typedef logic [OP_COUNT_W-1:0] opc_t;

  state_t           state;
  logic [WIDTH-1:0] x_sr;
  logic [WIDTH-1:0] y_sr;
  logic [WIDTH-1:0] res_sr;
  logic             bin_q;
  cnt_t             bit_cnt;

  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  opc_t             op_cnt_q;

  logic             cell_d;
  logic             cell_bout;

  sub_cell u_cell (
    .a    (x_sr[0]),
    .b    (y_sr[0]),
    .bin  (bin_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // Sequencer: capture operands, walk WIDTH bits through the cell, then publish results
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      x_sr     <= '0;
      y_sr     <= '0;
      res_sr   <= '0;
      bin_q    <= 1'b0;
      bit_cnt  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      op_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            x_sr    <= bus.x;
            y_sr    <= bus.y;
            res_sr  <= '0;
            bin_q   <= 1'b0;
            bit_cnt <= '0;
            busy_q  <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          // Result fills from the top so the first (LSB) bit lands in position 0
          x_sr    <= x_sr >> 1;
          y_sr    <= y_sr >> 1;
          res_sr  <= {cell_d, res_sr[WIDTH-1:1]};
          bin_q   <= cell_bout;
          bit_cnt <= bit_cnt + cnt_t'(1);
          if (bit_cnt == cnt_t'(WIDTH - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          diff_q   <= res_sr;
          borrow_q <= bin_q;
          done_q   <= 1'b1;
          op_cnt_q <= op_cnt_q + opc_t'(1);
          busy_q   <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.diff     = diff_q;
  assign bus.borrow   = borrow_q;
  assign bus.op_count = op_cnt_q;

endmodule

// File: tb/tb_sub_sequencer.sv
// tb/tb_sub_sequencer.sv - directed self-checking bench for sub_sequencer at WIDTH=4
module tb_sub_sequencer;

  localparam int W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // 50 MHz clock
  always #10 clk = ~clk;

  sub_sequencer_if #(.WIDTH(W)) bus ();

  sub_sequencer #(.WIDTH(W)) dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .bus      (bus)
  );

  // Issue one operation from a falling edge and return at the falling edge where done is seen.
  // lat counts edges from acceptance to done; -1 means done never arrived within the budget.
  task automatic run_op(input logic [3:0] xv, input logic [3:0] yv,
                        output int lat, output int busy_cyc, output bit early);
    logic [3:0] d0;
    logic       b0;
    d0       = bus.diff;
    b0       = bus.borrow;
    early    = 1'b0;
    busy_cyc = 0;
    lat      = -1;
    bus.x     = xv;
    bus.y     = yv;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.x     = ~xv;
    bus.y     = xv + 4'd1;
    for (int k = 0; k < 20; k++) begin
      if (bus.busy) busy_cyc++;
      if (bus.done) begin
        lat = k;
        break;
      end
      if (bus.diff !== d0 || bus.borrow !== b0) early = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.x     = 4'd5;
    bus.y     = 4'd9;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    n_checks++; if (bus.diff !== 4'h0) begin n_fail++; $display("FAIL reset_diff got=%h exp=0", bus.diff); end
    n_checks++; if (bus.borrow !== 1'b0) begin n_fail++; $display("FAIL reset_borrow got=%b exp=0", bus.borrow); end
    n_checks++; if (bus.op_count !== 8'd0) begin n_fail++; $display("FAIL reset_op_count got=%0d exp=0", bus.op_count); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat, bc;
    bit early;
    run_op(4'd7, 4'd3, lat, bc, early);
    n_checks++; if (lat != 5) begin n_fail++; $display("FAIL basic_latency got=%0d exp=5", lat); end
    n_checks++; if (bc != 5) begin n_fail++; $display("FAIL basic_busy_cycles got=%0d exp=5", bc); end
    n_checks++; if (early !== 1'b0) begin n_fail++; $display("FAIL basic_partial_result got=%b exp=0", early); end
    n_checks++; if (bus.diff !== 4'h4) begin n_fail++; $display("FAIL basic_diff got=%h exp=4", bus.diff); end
    n_checks++; if (bus.borrow !== 1'b0) begin n_fail++; $display("FAIL basic_borrow got=%b exp=0", bus.borrow); end
    n_checks++; if (bus.op_count !== 8'd1) begin n_fail++; $display("FAIL basic_op_count got=%0d exp=1", bus.op_count); end
    @(negedge clk);
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL basic_done_one_cycle got=%b exp=0", bus.done); end
    n_checks++; if (bus.diff !== 4'h4) begin n_fail++; $display("FAIL basic_diff_hold got=%h exp=4", bus.diff); end
  endtask

  task automatic test_borrow();
    int lat, bc;
    bit early;
    run_op(4'd3, 4'd7, lat, bc, early);
    n_checks++; if (lat != 5) begin n_fail++; $display("FAIL borrow1_latency got=%0d exp=5", lat); end
    n_checks++; if (bus.diff !== 4'hC) begin n_fail++; $display("FAIL borrow1_diff got=%h exp=c", bus.diff); end
    n_checks++; if (bus.borrow !== 1'b1) begin n_fail++; $display("FAIL borrow1_borrow got=%b exp=1", bus.borrow); end
    n_checks++; if (bus.op_count !== 8'd2) begin n_fail++; $display("FAIL borrow1_op_count got=%0d exp=2", bus.op_count); end
    @(negedge clk);
    run_op(4'd0, 4'd15, lat, bc, early);
    n_checks++; if (early !== 1'b0) begin n_fail++; $display("FAIL borrow2_partial_result got=%b exp=0", early); end
    n_checks++; if (bus.diff !== 4'h1) begin n_fail++; $display("FAIL borrow2_diff got=%h exp=1", bus.diff); end
    n_checks++; if (bus.borrow !== 1'b1) begin n_fail++; $display("FAIL borrow2_borrow got=%b exp=1", bus.borrow); end
    n_checks++; if (bus.op_count !== 8'd3) begin n_fail++; $display("FAIL borrow2_op_count got=%0d exp=3", bus.op_count); end
    @(negedge clk);
  endtask

  task automatic test_equal();
    int lat, bc;
    bit early;
    run_op(4'd10, 4'd10, lat, bc, early);
    n_checks++; if (bus.diff !== 4'h0) begin n_fail++; $display("FAIL equal_diff got=%h exp=0", bus.diff); end
    n_checks++; if (bus.borrow !== 1'b0) begin n_fail++; $display("FAIL equal_borrow got=%b exp=0", bus.borrow); end
    n_checks++; if (bus.op_count !== 8'd4) begin n_fail++; $display("FAIL equal_op_count got=%0d exp=4", bus.op_count); end
    @(negedge clk);
  endtask

  task automatic test_ignore_busy();
    int  lat;
    bit  extra_activity;
    lat = -1;
    extra_activity = 1'b0;
    bus.x = 4'd9; bus.y = 4'd5; bus.start = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.x = 4'd1; bus.y = 4'd1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 2; k < 20; k++) begin
      if (bus.done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    n_checks++; if (lat != 5) begin n_fail++; $display("FAIL ignore_latency got=%0d exp=5", lat); end
    n_checks++; if (bus.diff !== 4'h4) begin n_fail++; $display("FAIL ignore_diff got=%h exp=4", bus.diff); end
    n_checks++; if (bus.borrow !== 1'b0) begin n_fail++; $display("FAIL ignore_borrow got=%b exp=0", bus.borrow); end
    n_checks++; if (bus.op_count !== 8'd5) begin n_fail++; $display("FAIL ignore_op_count got=%0d exp=5", bus.op_count); end
    repeat (10) begin
      @(negedge clk);
      if (bus.busy || bus.done) extra_activity = 1'b1;
    end
    n_checks++; if (extra_activity !== 1'b0) begin n_fail++; $display("FAIL ignore_not_queued got=%b exp=0", extra_activity); end
    n_checks++; if (bus.op_count !== 8'd5) begin n_fail++; $display("FAIL ignore_op_count_after got=%0d exp=5", bus.op_count); end
  endtask

  task automatic test_reset_mid();
    int lat, bc;
    bit early;
    bit seen_done;
    seen_done = 1'b0;
    bus.x = 4'd12; bus.y = 4'd3; bus.start = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
    n_checks++; if (bus.diff !== 4'h0) begin n_fail++; $display("FAIL midrst_diff got=%h exp=0", bus.diff); end
    n_checks++; if (bus.borrow !== 1'b0) begin n_fail++; $display("FAIL midrst_borrow got=%b exp=0", bus.borrow); end
    n_checks++; if (bus.op_count !== 8'd0) begin n_fail++; $display("FAIL midrst_op_count got=%0d exp=0", bus.op_count); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen_done = 1'b1;
    end
    n_checks++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL midrst_no_done got=%b exp=0", seen_done); end
    run_op(4'd15, 4'd1, lat, bc, early);
    n_checks++; if (lat != 5) begin n_fail++; $display("FAIL midrst_next_latency got=%0d exp=5", lat); end
    n_checks++; if (bus.diff !== 4'hE) begin n_fail++; $display("FAIL midrst_next_diff got=%h exp=e", bus.diff); end
    n_checks++; if (bus.borrow !== 1'b0) begin n_fail++; $display("FAIL midrst_next_borrow got=%b exp=0", bus.borrow); end
    n_checks++; if (bus.op_count !== 8'd1) begin n_fail++; $display("FAIL midrst_next_op_count got=%0d exp=1", bus.op_count); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int         lat, bc;
    bit         early;
    logic [3:0] xv, yv, exp_d;
    logic       exp_b;
    logic [7:0] exp_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) begin
      xv      = 4'(i);
      yv      = 4'(i * 5 + i / 16);
      exp_d   = xv - yv;
      exp_b   = (xv < yv);
      exp_cnt = 8'(i + 1);
      run_op(xv, yv, lat, bc, early);
      n_checks++; if (lat != 5) begin n_fail++; $display("FAIL b2b_latency op=%0d got=%0d exp=5", i, lat); end
      n_checks++; if (bus.diff !== exp_d) begin n_fail++; $display("FAIL b2b_diff op=%0d x=%0d y=%0d got=%h exp=%h", i, xv, yv, bus.diff, exp_d); end
      n_checks++; if (bus.borrow !== exp_b) begin n_fail++; $display("FAIL b2b_borrow op=%0d x=%0d y=%0d got=%b exp=%b", i, xv, yv, bus.borrow, exp_b); end
      n_checks++; if (bus.op_count !== exp_cnt) begin n_fail++; $display("FAIL b2b_op_count op=%0d got=%0d exp=%0d", i, bus.op_count, exp_cnt); end
    end
    @(negedge clk);
    n_checks++; if (bus.op_count !== 8'd0) begin n_fail++; $display("FAIL b2b_wrap got=%0d exp=0", bus.op_count); end
  endtask

  // Scenario sequence
  initial begin
    bus.start = 1'b0;
    bus.x     = '0;
    bus.y     = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_borrow();
    test_equal();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sub_sequencer.md
SUB_SEQUENCER -- requirements
Module: sub_sequencer

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits; legal range 2..16.
REQ-002 CLOCK_50  in  1  system clock (50 MHz); all state changes on its rising edge.
REQ-003 RESET_N  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 start  in  1  one-cycle request to begin a subtraction; already synchronised and edge-detected upstream.
REQ-005 x  in  WIDTH  minuend, unsigned.
REQ-006 y  in  WIDTH  subtrahend, unsigned.
REQ-007 busy  out  1  high while an operation is in progress.
REQ-008 done  out  1  one-cycle pulse when diff/borrow are updated.
REQ-009 diff  out  WIDTH  registered result (x - y) mod 2^WIDTH.
REQ-010 borrow  out  1  registered final borrow; high when x < y.
REQ-011 op_count  out  8  number of completed operations, wraps.

Function
REQ-012 FSM states: IDLE, SHIFT, DONE; there is no other reachable state.
REQ-013 IDLE with start=1: capture x and y into shift registers, clear the internal borrow, clear the bit counter, assert busy, and go to SHIFT.
REQ-014 IDLE with start=0: hold all outputs.
REQ-015 SHIFT: each cycle processes one bit, LSB first, through a single one-bit subtractor cell.
REQ-016 Cell equations: d = a^b^bin; bout = (~a&b) | (~a&bin) | (b&bin).
REQ-017 In SHIFT, shift d into the result register MSB-first so that bit 0 ends in position 0, register bout as the next bin, and increment the counter.
REQ-018 SHIFT lasts exactly WIDTH cycles, then goes to DONE.
REQ-019 DONE: load diff and borrow from the internal registers, pulse done for one cycle, increment op_count, deassert busy, and go to IDLE.
REQ-020 Latency: with start accepted at edge t, done is high during the cycle after edge t+WIDTH+1, and diff/borrow are valid from that same cycle.
REQ-021 diff and borrow hold their values until the next DONE; they never show partial results.
REQ-022 start asserted while busy=1 (SHIFT or DONE) is ignored and is not queued.
REQ-023 x and y changing after acceptance have no effect on the operation in progress.
REQ-024 start in the cycle immediately after done is accepted normally (back-to-back issue).
REQ-025 op_count wraps from 255 to 0 with no flag.
REQ-026 Boundary results:
  - x=y gives diff=0, borrow=0.
  - x=0, y=2^WIDTH-1 gives diff=1, borrow=1.

Reset
REQ-027 RESET_N low forces immediately, independent of the clock: state IDLE, busy=0, done=0, diff=0, borrow=0, op_count=0, and the shift registers and counter cleared.
REQ-028 Reset asserted mid-operation aborts the operation; no done pulse is produced and op_count is not incremented.
REQ-029 The first start after reset release is accepted on the first rising edge at which RESET_N is high.

Structure
REQ-030 Shared package sub_seq_pkg holds:
  - the state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - the default WIDTH constant;
  - the op_count width constant (8).
REQ-031 One sub-module, sub_cell (inputs a, b, bin; outputs d, bout), implements REQ-016 and is instantiated exactly once.
REQ-032 The bit counter is $clog2(WIDTH+1) bits wide.
REQ-033 There are no latches; every register sits in a block sensitive to posedge CLOCK_50 or negedge RESET_N.
REQ-034 There are no combinational paths from inputs to outputs.

Verification (WIDTH=4)
REQ-035 x=7, y=3, start pulse -> busy high for 5 cycles; done pulse 5 cycles after acceptance; diff=4'h4, borrow=0, op_count=1.
REQ-036 x=3, y=7 -> diff=4'hC, borrow=1; then x=0, y=15 -> diff=4'h1, borrow=1.
REQ-037 x=9, y=5 accepted, then start pulsed again 2 cycles later with x=1, y=1 -> the second start is ignored; diff=4'h4, borrow=0; op_count increments once.
REQ-038 RESET_N pulsed low during SHIFT (cycle 2) -> outputs go to 0 immediately; no done pulse; the next op x=15, y=1 gives diff=4'hE, borrow=0, op_count=1.
REQ-039 256 back-to-back operations with start issued the cycle after each done -> no lost requests; op_count returns to 0 and diff/borrow are correct for every operation.
